// File: rtl/zap_predecode_mem_seq_pkg.sv
// zap_predecode_mem_seq_pkg: states, LDM/STM field positions and micro-op encoders for the predecode sequencer.
package zap_predecode_mem_seq_pkg;
  typedef enum logic [1:0] {IDLE, SEQ, WB, PCLD} state_t;
  localparam logic [3:0] NV = 4'hF;
  localparam logic [2:0] LDM_STM_OP = 3'b100;
  localparam int COND_HI = 31;
  localparam int COND_LO = 28;
  localparam int OP_HI = 27;
  localparam int OP_LO = 25;
  localparam int P_BIT = 24;
  localparam int U_BIT = 23;
  localparam int S_BIT = 22;
  localparam int W_BIT = 21;
  localparam int L_BIT = 20;
  localparam int RN_HI = 19;
  localparam int RN_LO = 16;
  localparam int USER_BIT = 32;
  function automatic logic [31:0] mem_op(input logic [3:0] cond, input logic l, input logic u,
                                         input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] imm);
    return {cond, 3'b010, 1'b1, u, 2'b00, l, rn, rd, imm};
  endfunction
  function automatic logic [31:0] alu_imm(input logic [3:0] cond, input logic add, input logic [3:0] rn,
                                          input logic [7:0] imm8);
    return {cond, 3'b001, add ? 4'b0100 : 4'b0010, 1'b0, rn, rn, 4'd0, imm8};
  endfunction
endpackage

// File: rtl/zap_predecode_mem_seq_popcnt_pri.sv
// zap_predecode_popcnt_pri: popcount of the full register list plus lowest-set-bit pick over the remaining list.
module zap_predecode_popcnt_pri #(
  parameter int MAX_LIST = 16
) (
  input  logic [MAX_LIST-1:0]         list,
  input  logic [MAX_LIST-1:0]         rem,
  output logic [$clog2(MAX_LIST):0]   count,
  output logic [$clog2(MAX_LIST)-1:0] idx,
  output logic [MAX_LIST-1:0]         rest
);
  localparam int CW = $clog2(MAX_LIST) + 1;
  localparam int IW = $clog2(MAX_LIST);
  always_comb begin
    count = '0;
    idx = '0;
    for (int i = 0; i < MAX_LIST; i++) count = count + CW'(list[i]);
    for (int i = MAX_LIST - 1; i >= 0; i--) if (rem[i]) idx = IW'(i);
  end
  assign rest = rem & (rem - MAX_LIST'(1));
endmodule

// File: rtl/zap_predecode_mem_seq.sv
// zap_predecode_mem_seq: passes instructions to decode and expands LDM/STM into LDR/STR micro-op sequences.
// Optional ZAP_PREDECODE_UOP_COUNT_EN adds a free-running emitted micro-op counter.
module zap_predecode_mem_seq
  import zap_predecode_mem_seq_pkg::*;
#(
  parameter int ARCH_REGS = 32,
  parameter int MAX_LIST  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic [31:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic [31:0] i_pc_ff,
  input  logic [31:0] i_pc_plus_8_ff,
  input  logic        i_irq,
  input  logic        i_fiq,
  input  logic        i_abt,
  input  logic [1:0]  i_taken,
  output logic [35:0] o_instruction_ff,
  output logic        o_instruction_valid_ff,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff,
  output logic        o_irq_ff,
  output logic        o_fiq_ff,
  output logic        o_abt_ff,
  output logic [1:0]  o_taken_ff,
  output logic        o_stall_from_predecode
`ifdef ZAP_PREDECODE_UOP_COUNT_EN
  ,
  output logic [31:0] o_uop_count_ff
`endif
);
  localparam int NW = $clog2(MAX_LIST) + 1;
  localparam int OW = NW + 3;
  localparam int RW = $clog2(ARCH_REGS);
  localparam int IW = $clog2(MAX_LIST);
  state_t state, nst, ph, after;
  logic [MAX_LIST-1:0] list, rem, rem_q, rest;
  logic signed [OW-1:0] off, off_q, noff, start, n4;
  logic [OW-1:0] mag;
  logic [NW-1:0] n, n_q, cnt;
  logic [IW-1:0] idx;
  logic [3:0] cond, cond_q;
  logic [RW-1:0] rn, rn_q;
  logic l, l_q, u, u_q, wb_f, wb_q, pcld_f, pcld_q, usr, usr_q;
  logic [31:0] op, pc, pc_q, pc8, pc8_q;
  logic [1:0] tk, tk_q;
  logic [35:0] ins;
  logic det, acc, emit, clr, hold, pend_irq, pend_fiq;
  assign list = i_instruction[MAX_LIST-1:0];
  assign det = i_instruction_valid & ~i_abt & (i_instruction[OP_HI:OP_LO] == LDM_STM_OP) & (|list);
  assign acc = (state == IDLE) & det;
  assign clr = i_reset | i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
  assign hold = i_data_stall | i_stall_from_shifter | i_stall_from_issue;
  zap_predecode_popcnt_pri #(.MAX_LIST(MAX_LIST)) u_pop (
    .list (list),
    .rem  (rem),
    .count(cnt),
    .idx  (idx),
    .rest (rest)
  );
  // Effective fields come straight from the fetch bus on the accept cycle, else from the captured parent.
  always_comb begin
    cond = acc ? i_instruction[COND_HI:COND_LO] : cond_q;
    l = acc ? i_instruction[L_BIT] : l_q;
    u = acc ? i_instruction[U_BIT] : u_q;
    rn = acc ? RW'(i_instruction[RN_HI:RN_LO]) : rn_q;
    n = acc ? cnt : n_q;
    n4 = OW'({n, 2'b00});
    start = i_instruction[U_BIT] ? (i_instruction[P_BIT] ? OW'(4) : OW'(0))
                                 : (i_instruction[P_BIT] ? -n4 : OW'(4) - n4);
    wb_f = acc ? (i_instruction[W_BIT] & ~(i_instruction[L_BIT] & list[i_instruction[RN_HI:RN_LO]])) : wb_q;
    pcld_f = acc ? (i_instruction[L_BIT] & list[MAX_LIST-1]) : pcld_q;
    usr = acc ? (i_instruction[S_BIT] & ~pcld_f) : usr_q;
    rem = acc ? (list & ~{i_instruction[L_BIT], {(MAX_LIST-1){1'b0}}}) : rem_q;
    off = acc ? start : off_q;
    pc = acc ? i_pc_ff : pc_q;
    pc8 = acc ? i_pc_plus_8_ff : pc8_q;
    tk = acc ? i_taken : tk_q;
    ph = acc ? ((|rem) ? SEQ : wb_f ? WB : PCLD) : state;
    emit = ph != IDLE;
    mag = OW'(off[OW-1] ? -off : off);
    op = (ph == WB) ? alu_imm(cond, u, 4'(rn), 8'(n4))
                    : mem_op(cond, (ph == PCLD) | l, ~off[OW-1], 4'(rn), (ph == PCLD) ? 4'hF : 4'(idx), 12'(mag));
    after = wb_f ? WB : pcld_f ? PCLD : IDLE;
    nst = (ph == SEQ) ? ((|rest) ? SEQ : after) : (ph == WB) ? (pcld_f ? PCLD : IDLE) : IDLE;
    // The PC load after a writeback must address relative to the already-updated base.
    noff = (ph == SEQ) ? off + OW'(4) : (ph == WB) ? (u ? off - n4 : off + n4) : off;
    ins = emit ? {4'd0, op} : {4'd0, i_instruction};
    ins[USER_BIT] = emit & usr;
  end
  assign o_stall_from_predecode = ~(i_reset | i_clear_from_writeback | i_clear_from_alu) & (nst != IDLE);
  always_ff @(posedge i_clk) begin
    if (clr) begin
      state <= IDLE;
      o_instruction_ff <= {4'd0, NV, 28'd0};
      o_instruction_valid_ff <= 1'b0;
      o_pc_ff <= 32'd0;
      o_pc_plus_8_ff <= 32'd8;
      o_irq_ff <= 1'b0;
      o_fiq_ff <= 1'b0;
      o_abt_ff <= 1'b0;
      o_taken_ff <= 2'd0;
      pend_irq <= 1'b0;
      pend_fiq <= 1'b0;
    end else if (!hold) begin
      state <= nst;
      rem_q <= rest;
      off_q <= noff;
      cond_q <= cond;
      l_q <= l;
      u_q <= u;
      rn_q <= rn;
      n_q <= n;
      wb_q <= wb_f;
      pcld_q <= pcld_f;
      usr_q <= usr;
      pc_q <= pc;
      pc8_q <= pc8;
      tk_q <= tk;
      o_instruction_ff <= ins;
      o_instruction_valid_ff <= emit | i_instruction_valid;
      o_pc_ff <= emit ? pc : i_pc_ff;
      o_pc_plus_8_ff <= emit ? pc8 : i_pc_plus_8_ff;
      o_taken_ff <= emit ? tk : i_taken;
      o_abt_ff <= ~emit & i_abt;
      // Interrupts seen during a sequence wait for the first instruction after it.
      o_irq_ff <= ~emit & (i_irq | pend_irq);
      o_fiq_ff <= ~emit & (i_fiq | pend_fiq);
      pend_irq <= emit & (i_irq | pend_irq);
      pend_fiq <= emit & (i_fiq | pend_fiq);
    end
  end
`ifdef ZAP_PREDECODE_UOP_COUNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) o_uop_count_ff <= 32'd0;
    else if (!clr && !hold && emit) o_uop_count_ff <= o_uop_count_ff + 32'd1;
  end
`endif
endmodule

// File: tb/tb_zap_predecode_mem_seq.sv
// tb_zap_predecode_mem_seq: directed and randomized checks of the predecode LDM/STM sequencer.
module tb_zap_predecode_mem_seq;
  logic i_clk = 1'b0;
  logic i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue;
  logic [31:0] i_instruction, i_pc_ff, i_pc_plus_8_ff;
  logic i_instruction_valid, i_irq, i_fiq, i_abt;
  logic [1:0] i_taken;
  logic [35:0] o_instruction_ff;
  logic o_instruction_valid_ff, o_irq_ff, o_fiq_ff, o_abt_ff, o_stall_from_predecode;
  logic [31:0] o_pc_ff, o_pc_plus_8_ff;
  logic [1:0] o_taken_ff;
`ifdef ZAP_PREDECODE_UOP_COUNT_EN
  logic [31:0] o_uop_count_ff;
`endif
  int tests = 0;
  int fails = 0;
  int uops = 0;
  bit pend = 1'b0;
  logic [35:0] exp_q[$];
  localparam logic [35:0] CLR_INS = {4'd0, 4'hF, 28'd0};
  localparam logic [31:0] ADD_W = 32'hE0821003;
  localparam logic [31:0] STM4_W = 32'hE8820078;

  zap_predecode_mem_seq dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear_from_writeback(i_clear_from_writeback),
    .i_data_stall(i_data_stall), .i_clear_from_alu(i_clear_from_alu),
    .i_stall_from_shifter(i_stall_from_shifter), .i_stall_from_issue(i_stall_from_issue),
    .i_instruction(i_instruction), .i_instruction_valid(i_instruction_valid),
    .i_pc_ff(i_pc_ff), .i_pc_plus_8_ff(i_pc_plus_8_ff), .i_irq(i_irq), .i_fiq(i_fiq), .i_abt(i_abt),
    .i_taken(i_taken), .o_instruction_ff(o_instruction_ff), .o_instruction_valid_ff(o_instruction_valid_ff),
    .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_irq_ff(o_irq_ff), .o_fiq_ff(o_fiq_ff),
    .o_abt_ff(o_abt_ff), .o_taken_ff(o_taken_ff), .o_stall_from_predecode(o_stall_from_predecode)
`ifdef ZAP_PREDECODE_UOP_COUNT_EN
    , .o_uop_count_ff(o_uop_count_ff)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic bit is_seq(input logic [31:0] w, input logic a);
    return !a && w[27:25] == 3'b100 && w[15:0] != 16'd0;
  endfunction

  function automatic logic [35:0] mem(input logic [3:0] c, input logic l, input logic [3:0] rn,
                                      input logic [3:0] rd, input int off, input logic usr);
    logic [31:0] a;
    a = off < 0 ? -off : off;
    return {3'd0, usr, c, 4'b0101, off >= 0, 2'b00, l, rn, rd, a[11:0]};
  endfunction

  // Architectural expansion: address each listed register in turn, then base update, then the PC load.
  function automatic void expand(input logic [31:0] w, input logic a);
    int n, base, i, pc_off, off;
    logic dowb, pcl, usr;
    if (!is_seq(w, a)) begin
      exp_q.push_back({4'd0, w});
      return;
    end
    n = 0;
    for (int r = 0; r < 16; r++) n += int'(w[r]);
    base = w[23] ? (w[24] ? 4 : 0) : (w[24] ? -4 * n : 4 - 4 * n);
    pcl = w[20] && w[15];
    usr = w[22] && !pcl;
    dowb = w[21] && !(w[20] && w[w[19:16]]);
    i = 0;
    pc_off = 0;
    for (int r = 0; r < 16; r++) if (w[r]) begin
      off = base + 4 * i;
      i++;
      if (pcl && r == 15) pc_off = off;
      else exp_q.push_back(mem(w[31:28], w[20], w[19:16], 4'(r), off, usr));
    end
    if (dowb) exp_q.push_back({3'd0, usr, w[31:28], 3'b001, w[23] ? 4'b0100 : 4'b0010, 1'b0,
                               w[19:16], w[19:16], 4'd0, 8'(4 * n)});
    if (pcl) exp_q.push_back(mem(w[31:28], 1'b1, w[19:16], 4'hF,
                                 pc_off - (dowb ? (w[23] ? 4 * n : -4 * n) : 0), usr));
  endfunction

  task automatic run(input logic [31:0] w, input logic a, input int irq_at, input bit model);
    logic [31:0] pc;
    logic [1:0] tk;
    bit sq;
    int k;
    pc = $urandom;
    tk = 2'($urandom_range(3));
    sq = is_seq(w, a);
    if (model) begin
      exp_q.delete();
      expand(w, a);
    end
    k = exp_q.size();
    i_instruction = w;
    i_instruction_valid = 1'b1;
    i_abt = a;
    i_pc_ff = pc;
    i_pc_plus_8_ff = pc + 32'd8;
    i_taken = tk;
    for (int j = 0; j < k; j++) begin
      i_irq = (j == irq_at);
      #1;
      chk("stall", 36'(o_stall_from_predecode), 36'(j < k - 1));
      @(posedge i_clk);
      #1;
      i_irq = 1'b0;
      chk("ins", o_instruction_ff, exp_q[j]);
      chk("valid", 36'(o_instruction_valid_ff), 36'd1);
      chk("pc", 36'(o_pc_ff), 36'(pc));
      chk("pc8", 36'(o_pc_plus_8_ff), 36'(pc + 32'd8));
      chk("taken", 36'(o_taken_ff), 36'(tk));
      chk("abt", 36'(o_abt_ff), 36'(a));
      chk("irq", 36'(o_irq_ff), sq ? 36'd0 : 36'(pend || irq_at == 0));
      if (sq) uops++;
    end
    if (sq && irq_at >= 0 && irq_at < k) pend = 1'b1;
    else if (!sq) pend = 1'b0;
    i_instruction_valid = 1'b0;
    i_abt = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int kind;
    logic a;
    i_reset = 1'b1;
    {i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue} = '0;
    {i_instruction, i_instruction_valid, i_pc_ff, i_pc_plus_8_ff, i_irq, i_fiq, i_abt, i_taken} = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ins", o_instruction_ff, CLR_INS);
    chk("rst_valid", 36'(o_instruction_valid_ff), 36'd0);
    chk("rst_pc", 36'(o_pc_ff), 36'd0);
    chk("rst_pc8", 36'(o_pc_plus_8_ff), 36'd8);
    chk("rst_taken", 36'(o_taken_ff), 36'd0);
    chk("rst_irq", 36'({o_irq_ff, o_fiq_ff, o_abt_ff}), 36'd0);
    chk("rst_stall", 36'(o_stall_from_predecode), 36'd0);
    i_reset = 1'b0;
    exp_q = '{{4'd0, ADD_W}};
    run(ADD_W, 1'b0, -1, 1'b0);
    exp_q = '{36'h0E5901000, 36'h0E5902004, 36'h0E280000C, 36'h0E510F004};
    run(32'hE8B08006, 1'b0, -1, 1'b0);
    exp_q = '{36'h0E50D4008, 36'h0E50D5004, 36'h0E24DD008};
    run(32'hE92D0030, 1'b0, -1, 1'b0);
    exp_q = '{36'h0E5900000, 36'h0E5901004};
    run(32'hE8B00003, 1'b0, -1, 1'b0);
    exp_q = '{36'h1E5901000};
    run(32'hE8D00002, 1'b0, -1, 1'b0);
    exp_q = '{36'h0E5823000, 36'h0E5824004, 36'h0E5825008, 36'h0E582600C};
    run(STM4_W, 1'b0, 1, 1'b0);
    exp_q = '{{4'd0, ADD_W}};
    run(ADD_W, 1'b0, -1, 1'b0);
    exp_q = '{{4'd0, 32'hE8B00000}};
    run(32'hE8B00000, 1'b0, -1, 1'b0);
    exp_q = '{{4'd0, 32'hE8B08006}};
    run(32'hE8B08006, 1'b1, -1, 1'b0);
    // Clear from ALU in the middle of a sequence abandons it.
    i_instruction = STM4_W;
    i_instruction_valid = 1'b1;
    i_pc_ff = 32'h100;
    i_pc_plus_8_ff = 32'h108;
    @(posedge i_clk);
    #1;
    chk("clr_op0", o_instruction_ff, 36'h0E5823000);
    uops++;
    i_clear_from_alu = 1'b1;
    #1;
    chk("clr_stall", 36'(o_stall_from_predecode), 36'd0);
    @(posedge i_clk);
    #1;
    i_clear_from_alu = 1'b0;
    chk("clr_ins", o_instruction_ff, CLR_INS);
    chk("clr_valid", 36'(o_instruction_valid_ff), 36'd0);
    chk("clr_pc8", 36'(o_pc_plus_8_ff), 36'd8);
    exp_q = '{{4'd0, ADD_W}};
    run(ADD_W, 1'b0, -1, 1'b0);
    // Data stall freezes a sequence and outranks a concurrent ALU clear.
    i_instruction = STM4_W;
    i_instruction_valid = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ds_op0", o_instruction_ff, 36'h0E5823000);
    uops++;
    i_data_stall = 1'b1;
    i_clear_from_alu = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge i_clk);
      #1;
      i_clear_from_alu = 1'b0;
      chk("ds_hold", o_instruction_ff, 36'h0E5823000);
    end
    i_data_stall = 1'b0;
    exp_q = '{36'h0E5823000, 36'h0E5824004, 36'h0E5825008, 36'h0E582600C};
    for (int j = 1; j < 4; j++) begin
      #1;
      chk("ds_stall", 36'(o_stall_from_predecode), 36'(j < 3));
      @(posedge i_clk);
      #1;
      chk("ds_op", o_instruction_ff, exp_q[j]);
      uops++;
    end
    i_instruction_valid = 1'b0;
    for (int t = 0; t < 60; t++) begin
      w = $urandom;
      kind = $urandom_range(9);
      a = ($urandom_range(9) == 0);
      w[31:28] = 4'($urandom_range(14));
      if (kind < 6) begin
        w[27:25] = 3'b100;
        if (kind == 0) w[15:0] = 16'd0;
        else if (kind == 1) w[15:0] = 16'(1) << $urandom_range(15);
      end else if (w[27:25] == 3'b100) w[27:25] = 3'b000;
      run(w, a, -1, 1'b1);
    end
`ifdef ZAP_PREDECODE_UOP_COUNT_EN
    chk("uop_count", 36'(o_uop_count_ff), 36'(uops));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
